mmio_console_tx: RTL and testbench

MMIO_CONSOLE_TX -- requirements
Module: mmio_console_tx

---
 rtl/mmio_console_tx.sv | 165 ++++++++++++++++
 tb/tb_mmio_console_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console_tx.sv
// Memory-mapped console transmitter: a byte FIFO fed by CPU stores, drained by an
// 8N1 serializer, with STATUS and a frame counter readable through a 16-byte window.
module mmio_console_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_write_en,
  input  logic [31:0] memory_write_address,
  input  logic [31:0] memory_write,
  input  logic [31:0] memory_read_address,
  output logic [31:0] memory_read_data,
  output logic        select,
  output logic        uart_tx
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  typedef enum logic [1:0] {OFF_TXDATA, OFF_STATUS, OFF_SENT, OFF_RSVD} reg_off_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              overflow_q, overflow_d;
  logic [31:0]       sent_q, sent_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic wr_hit, push_req, status_wr, sent_wr, push_ok, pop, frame_done;
  logic fifo_full, fifo_empty, bit_end;
  logic [4:0] count5;
  reg_off_e wr_off, rd_off;

  assign wr_off     = reg_off_e'(memory_write_address[3:2]);
  assign rd_off     = reg_off_e'(memory_read_address[3:2]);
  assign wr_hit     = memory_write_en && (memory_write_address[31:4] == BASE_ADDR[31:4]);
  assign push_req   = wr_hit && (wr_off == OFF_TXDATA);
  assign status_wr  = wr_hit && (wr_off == OFF_STATUS);
  assign sent_wr    = wr_hit && (wr_off == OFF_SENT);
  assign select     = (memory_read_address[31:4] == BASE_ADDR[31:4]);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A pop in the same cycle frees the slot, so a store to a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign bit_end    = (cnt_q == CNTW'(CLKS_PER_BIT - 1));
  assign count5     = 5'(count_q);
  assign uart_tx    = tx_q;
  assign memory_read_data = rdata_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_mem[rd_ptr_q];
        state_d = START;
        tx_d    = 1'b0;
        cnt_d   = '0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      STOP: if (bit_end) begin
        frame_done = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
    else if (status_wr)                overflow_d = 1'b0;

    sent_d = sent_q;
    if (sent_wr)         sent_d = '0;
    else if (frame_done) sent_d = sent_q + 32'd1;

    rdata_d = '0;
    if (select) begin
      unique case (rd_off)
        OFF_STATUS: rdata_d = {23'b0, count5, overflow_q, state_q != IDLE, fifo_empty, fifo_full};
        OFF_SENT:   rdata_d = sent_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is carried by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= memory_write[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sent_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      sent_q     <= sent_d;
      rdata_q    <= rdata_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_console_tx.sv
// Directed bench for mmio_console_tx: register window, FIFO fill/overflow, serial
// framing via a sampling receiver, mid-frame reset and SENT wrap/clear.
module tb_mmio_console_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          CPB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_write_en = 1'b0;
  logic [31:0] memory_write_address = '0;
  logic [31:0] memory_write = '0;
  logic [31:0] memory_read_address = '0;
  logic [31:0] memory_read_data;
  logic        select;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;

  mmio_console_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .memory_write_en      (memory_write_en),
    .memory_write_address (memory_write_address),
    .memory_write         (memory_write),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .select               (select),
    .uart_tx              (uart_tx)
  );

  always #5 clk = ~clk;

  // Sampling receiver: samples each bit mid-cell on falling edges.
  int unsigned cyc = 0;
  logic        rx_busy = 1'b0;
  int          rx_phase = 0;
  logic [7:0]  rx_byte = '0;
  int          rx_frame_err = 0;
  logic [7:0]  rx_q [$];
  int unsigned rx_start_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (uart_tx === 1'b0) begin
        rx_busy  <= 1'b1;
        rx_phase <= 1;
        rx_start_q.push_back(cyc);
      end
    end else begin
      if (rx_phase >= 6 && rx_phase <= 34 && (rx_phase % 4) == 2)
        rx_byte[(rx_phase - 6) / 4] <= uart_tx;
      if (rx_phase == 38) begin
        rx_q.push_back(rx_byte);
        if (uart_tx !== 1'b1) rx_frame_err <= rx_frame_err + 1;
      end
      if (rx_phase == 39) rx_busy <= 1'b0;
      rx_phase <= rx_phase + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after the store edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memory_write_en      = 1'b1;
    memory_write_address = a;
    memory_write         = d;
    @(negedge clk);
    memory_write_en      = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    memory_read_address = a;
    @(negedge clk);
    d = memory_read_data;
  endtask

  logic [31:0] rd;
  logic [9:0]  frame_bits;
  int          waited;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_tx_idle", {31'b0, uart_tx}, 32'd1);
    check("reset_rdata", memory_read_data, 32'd0);
    reset = 1'b1;

    // Window decode and reset values
    load(BASE + 32'd4, rd);
    check("status_after_reset", rd, 32'h0000_0002);
    memory_read_address = 32'h0000_1000;
    #1 check("select_outside", {31'b0, select}, 32'd0);
    load(32'h0000_1000, rd);
    check("load_outside", rd, 32'd0);
    memory_read_address = BASE + 32'd12;
    #1 check("select_reserved", {31'b0, select}, 32'd1);
    load(BASE + 32'd12, rd);
    check("load_reserved", rd, 32'd0);
    load(BASE + 32'd8, rd);
    check("sent_after_reset", rd, 32'd0);
    store(BASE + 32'd12, 32'h55);
    store(32'h0000_1000, 32'h66);
    load(BASE + 32'd4, rd);
    check("ignored_stores_status", rd, 32'h0000_0002);

    // Single frame 0xA5: start, LSB-first data, stop, CPB cycles each
    store(BASE, 32'hDEAD_BEA5);
    check("tx_high_after_push", {31'b0, uart_tx}, 32'd1);
    memory_read_address = BASE + 32'd4;
    frame_bits = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (uart_tx !== frame_bits[b]) begin
          check($sformatf("frame_a5_bit%0d_cyc%0d", b, c), {31'b0, uart_tx}, {31'b0, frame_bits[b]});
        end
        if (b == 5 && c == 0) check("status_busy_mid_frame", memory_read_data, 32'h0000_0006);
      end
    end
    check("frame_a5_waveform_end", {31'b0, uart_tx}, 32'd1);
    repeat (2) @(negedge clk);
    load(BASE + 32'd8, rd);
    check("sent_after_a5", rd, 32'd1);
    load(BASE + 32'd4, rd);
    check("status_idle_after_a5", rd, 32'h0000_0002);

    // Nine consecutive stores into a depth-8 FIFO, then one store while full
    for (int i = 1; i <= 9; i++) store(BASE, i);
    load(BASE + 32'd4, rd);
    check("status_full_no_ovf", rd, 32'h0000_0085);
    store(BASE, 32'h0A);
    load(BASE + 32'd4, rd);
    check("status_full_ovf", rd, 32'h0000_008D);
    store(BASE + 32'd4, 32'h0);
    load(BASE + 32'd4, rd);
    check("status_ovf_cleared", rd, 32'h0000_0085);

    waited = 0;
    while (rx_q.size() < 10 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check("rx_count_after_burst", rx_q.size(), 32'd10);
    repeat (100) @(negedge clk);
    check("rx_count_dropped_byte", rx_q.size(), 32'd10);
    check("rx_byte_a5", {24'b0, rx_q[0]}, 32'hA5);
    for (int i = 1; i <= 9; i++)
      check($sformatf("rx_byte_%0d", i), {24'b0, rx_q[i]}, i);
    for (int i = 2; i <= 9; i++)
      check($sformatf("back_to_back_gap_%0d", i), rx_start_q[i] - rx_start_q[i-1], 40);
    load(BASE + 32'd8, rd);
    check("sent_after_burst", rd, 32'd10);
    load(BASE + 32'd4, rd);
    check("status_after_burst", rd, 32'h0000_0002);

    // Reset during data bit 3 of 0x5A with two bytes queued
    store(BASE, 32'h5A);
    store(BASE, 32'h11);
    store(BASE, 32'h22);
    repeat (12) @(negedge clk);
    check("abort_frame_bit2", {31'b0, uart_tx}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_frame_bit3", {31'b0, uart_tx}, 32'd1);
    repeat (2) @(negedge clk);
    check("abort_frame_bit3_late", {31'b0, uart_tx}, 32'd1);
    reset = 1'b0;
    #1 check("reset_async_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_async_rdata", memory_read_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    load(BASE + 32'd4, rd);
    check("status_after_abort", rd, 32'h0000_0002);
    load(BASE + 32'd8, rd);
    check("sent_after_abort", rd, 32'd0);
    repeat (60) @(negedge clk);
    check("no_frames_after_abort", rx_q.size(), 32'd10);

    // SENT wrap from all-ones, then clear racing a stop-end increment
    force dut.sent_q = 32'hFFFF_FFFF;
    #1 release dut.sent_q;
    load(BASE + 32'd8, rd);
    check("sent_preload", rd, 32'hFFFF_FFFF);
    store(BASE, 32'h3C);
    repeat (41) @(negedge clk);
    load(BASE + 32'd8, rd);
    check("sent_wrap", rd, 32'd0);
    store(BASE, 32'hC3);
    repeat (40) @(negedge clk);
    store(BASE + 32'd8, 32'h1234);
    load(BASE + 32'd8, rd);
    check("sent_clear_wins", rd, 32'd0);
    repeat (4) @(negedge clk);
    check("rx_count_final", rx_q.size(), 32'd12);
    check("rx_byte_3c", {24'b0, rx_q[10]}, 32'h3C);
    check("rx_byte_c3", {24'b0, rx_q[11]}, 32'hC3);
    check("rx_stop_bits", rx_frame_err, 32'd0);
    check("final_tx_idle", {31'b0, uart_tx}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
